mblk_scan_addr_gen: RTL and testbench
=====================================

Name: mblk_scan_addr_gen

Overview:
- Upstream address sequencer for the macroblock processing stages.
- Walks a raster-stored frame buffer in macroblock order: pixel raster inside each block, blocks left-to-right, then block rows top-to-bottom.
- Block size is selected per frame by a teMacroBlockType code.
- Emits one linear pixel address per beat on a valid/ready stream, plus block and frame framing flags, to the frame-buffer read port feeding the block engine.

Parameters:
- DIM_W, 12, width of the frame width/height inputs, in pixels.
- ADDR_W, 22, width of the linear pixel address output.

Ports:
- iClk  in  1  clock; single clock domain.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  start request, sampled only in IDLE.
- iMbType  in  2  teMacroBlockType: 01=64x64, 10=32x32, 11=16x16, 00=invalid.
- iFrameW  in  DIM_W  frame width in pixels.
- iFrameH  in  DIM_W  frame height in pixels.
- oBusy  out  1  high while not IDLE.
- oErr  out  1  one-cycle pulse when a start is rejected.
- oDone  out  1  one-cycle pulse after the last beat is accepted.
- oValid  out  1  address beat valid.
- iReady  in  1  downstream accepts beat when oValid&&iReady.
- oAddr  out  ADDR_W  linear pixel address = y*FrameW + x.
- oMbFirst  out  1  beat is pixel (0,0) of a macroblock.
- oMbLast  out  1  beat is last pixel of a macroblock.
- oFrameLast  out  1  beat is last pixel of the frame.

Behaviour:
- Reset: every output 0. State IDLE. Internal counters 0. Applies from any state, including mid-frame; no partial beat or oDone is produced afterwards.
- States: IDLE, RUN.
- IDLE with iStart=1: latch iMbType, iFrameW and iFrameH. S = 64/32/16 for type 01/10/11.
- Start is rejected (oErr=1 next cycle, stay IDLE, no beats) if any of these hold:
  - type=00;
  - W=0 or H=0;
  - W or H not a multiple of S;
  - W*H > 2^ADDR_W.
- A valid start moves to RUN. oValid=1 on the cycle after iStart is sampled, with oAddr=0 and oMbFirst=1.
- Counters:
  - px, py: pixel position in block, 0..S-1.
  - mbx: block column, 0..W/S-1.
  - mby: block row, 0..H/S-1.
- Scan order: px fastest, then py, then mbx, then mby.
- Address is built incrementally; no per-beat multiplier.
  - Keep lineBase = (mby*S+py)*W + mbx*S. oAddr = lineBase + px.
  - px wraps: lineBase += W.
  - Block ends (px=py=S-1): lineBase = blockRowBase + (mbx+1)*S.
  - Block row ends: blockRowBase += S*W and lineBase = blockRowBase.
- Handshake:
  - Counters advance only on oValid&&iReady.
  - With iReady low, oValid and all output fields hold stable.
  - Throughput is 1 beat/cycle with iReady held high.
  - oValid never drops without acceptance.
- Flags: combinational from the current counters, registered with oAddr.
  - oMbFirst: px=0 and py=0.
  - oMbLast: px=py=S-1.
  - oFrameLast: oMbLast with mbx and mby both at their maxima.
- End of frame: when the oFrameLast beat is accepted, the next cycle has oValid=0 and oDone=1 for one cycle, state IDLE.
- A new iStart is accepted in the cycle after oDone, or in the oDone cycle itself, since state is IDLE then.
- iStart in RUN is ignored; no oErr.
- Changes to iMbType, iFrameW or iFrameH in RUN have no effect.
- oBusy=1 in RUN; 0 in IDLE, including the oDone cycle.

Test Plan:
- W=32, H=32, type 11 (S=16), iReady=1 -> 1024 beats, consecutive, then oDone.
  - Beats 0..15: addr 0..15.
  - Beat 16: addr 32.
  - Beat 255: addr 495, oMbLast=1.
  - Beat 256: addr 16, oMbFirst=1.
  - Beat 512: addr 512.
  - Beat 1023: addr 1023 with oMbLast=oFrameLast=1.
- W=64, H=64, type 01 -> plain raster addr 0..4095, single oMbFirst at beat 0, oFrameLast at beat 4095.
- Invalid starts, each with no oValid and oBusy=0 -> oErr pulse exactly one cycle after iStart:
  - type 00, W=32, H=32;
  - type 11, W=40, H=32;
  - type 10, W=0, H=32.
- Backpressure: W=32, H=32, type 11, iReady low on beats 15..17 for 3 cycles each. oAddr holds at 15, then 32, then 33 while stalled. No address skipped or duplicated; total 1024 accepted beats.
- Reset mid-frame: assert iRst at beat 300 -> next cycle all outputs 0, no oDone. A fresh start then restarts at addr 0.
- iStart pulsed during RUN, and config inputs changed mid-frame -> ignored, sequence identical to the undisturbed run. Back-to-back start in the oDone cycle -> new frame's first beat (addr 0) on the following cycle.

Source files
------------

// File: rtl/mblk_scan_addr_gen.sv
// Macroblock-order address sequencer: walks a raster frame buffer block by block
// and emits one linear pixel address per accepted beat, with block/frame framing flags.
module mblk_scan_addr_gen #(
    parameter int DIM_W  = 12,
    parameter int ADDR_W = 22
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic [1:0]        iMbType,
    input  logic [DIM_W-1:0]  iFrameW,
    input  logic [DIM_W-1:0]  iFrameH,
    output logic              oBusy,
    output logic              oErr,
    output logic              oDone,
    output logic              oValid,
    input  logic              iReady,
    output logic [ADDR_W-1:0] oAddr,
    output logic              oMbFirst,
    output logic              oMbLast,
    output logic              oFrameLast
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [63:0] AREA_MAX = 64'd1 << ADDR_W;

    state_t state_reg, state_next;

    // Frame configuration captured at start
    logic [DIM_W-1:0]  w_reg, w_next;
    logic [ADDR_W-1:0] sw_reg, sw_next;
    logic [5:0]        s_last_reg, s_last_next;
    logic [DIM_W-1:0]  cols_last_reg, cols_last_next;
    logic [DIM_W-1:0]  rows_last_reg, rows_last_next;

    // Scan position of the beat currently presented
    logic [5:0]        px_reg, px_next;
    logic [5:0]        py_reg, py_next;
    logic [DIM_W-1:0]  mbx_reg, mbx_next;
    logic [DIM_W-1:0]  mby_reg, mby_next;
    logic [ADDR_W-1:0] col_off_reg, col_off_next;
    logic [ADDR_W-1:0] row_base_reg, row_base_next;
    logic [ADDR_W-1:0] line_base_reg, line_base_next;

    logic              valid_reg, valid_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              mb_first_reg, mb_first_next;
    logic              mb_last_reg, mb_last_next;
    logic              frame_last_reg, frame_last_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic [2:0]         lg_in;
    logic [5:0]         s_last_in;
    logic [2*DIM_W-1:0] area_in;
    logic               bad_start;
    logic               accept;

    assign accept = valid_reg && iReady;

    // Start qualification; the single multiply here only runs on the start cycle
    always_comb begin
        lg_in     = 3'd4;
        s_last_in = 6'd15;
        case (iMbType)
            2'b01:   begin lg_in = 3'd6; s_last_in = 6'd63; end
            2'b10:   begin lg_in = 3'd5; s_last_in = 6'd31; end
            default: begin lg_in = 3'd4; s_last_in = 6'd15; end
        endcase
        area_in   = (2*DIM_W)'(iFrameW) * (2*DIM_W)'(iFrameH);
        bad_start = (iMbType == 2'b00) || (iFrameW == '0) || (iFrameH == '0)
                 || ((iFrameW & DIM_W'(s_last_in)) != '0)
                 || ((iFrameH & DIM_W'(s_last_in)) != '0)
                 || (64'(area_in) > AREA_MAX);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (iStart && !bad_start) state_next = RUN;
            RUN:     if (accept && frame_last_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        w_next          = w_reg;
        sw_next         = sw_reg;
        s_last_next     = s_last_reg;
        cols_last_next  = cols_last_reg;
        rows_last_next  = rows_last_reg;
        px_next         = px_reg;
        py_next         = py_reg;
        mbx_next        = mbx_reg;
        mby_next        = mby_reg;
        col_off_next    = col_off_reg;
        row_base_next   = row_base_reg;
        line_base_next  = line_base_reg;
        valid_next      = valid_reg;
        addr_next       = addr_reg;
        mb_first_next   = mb_first_reg;
        mb_last_next    = mb_last_reg;
        frame_last_next = frame_last_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (iStart) begin
                    if (bad_start) begin
                        err_next = 1'b1;
                    end else begin
                        w_next          = iFrameW;
                        sw_next         = ADDR_W'(iFrameW) << lg_in;
                        s_last_next     = s_last_in;
                        cols_last_next  = (iFrameW >> lg_in) - DIM_W'(1);
                        rows_last_next  = (iFrameH >> lg_in) - DIM_W'(1);
                        px_next         = '0;
                        py_next         = '0;
                        mbx_next        = '0;
                        mby_next        = '0;
                        col_off_next    = '0;
                        row_base_next   = '0;
                        line_base_next  = '0;
                        valid_next      = 1'b1;
                        addr_next       = '0;
                        mb_first_next   = 1'b1;
                        mb_last_next    = 1'b0;
                        frame_last_next = 1'b0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (frame_last_reg) begin
                        valid_next      = 1'b0;
                        addr_next       = '0;
                        mb_first_next   = 1'b0;
                        mb_last_next    = 1'b0;
                        frame_last_next = 1'b0;
                        done_next       = 1'b1;
                    end else begin
                        if (px_reg != s_last_reg) begin
                            px_next = px_reg + 6'd1;
                        end else begin
                            px_next = '0;
                            if (py_reg != s_last_reg) begin
                                py_next        = py_reg + 6'd1;
                                line_base_next = line_base_reg + ADDR_W'(w_reg);
                            end else begin
                                py_next = '0;
                                if (mbx_reg != cols_last_reg) begin
                                    mbx_next       = mbx_reg + DIM_W'(1);
                                    col_off_next   = col_off_reg + ADDR_W'(s_last_reg) + ADDR_W'(1);
                                    line_base_next = row_base_reg + col_off_next;
                                end else begin
                                    // Next block row starts S lines further down
                                    mbx_next       = '0;
                                    mby_next       = mby_reg + DIM_W'(1);
                                    col_off_next   = '0;
                                    row_base_next  = row_base_reg + sw_reg;
                                    line_base_next = row_base_next;
                                end
                            end
                        end
                        addr_next       = line_base_next + ADDR_W'(px_next);
                        mb_first_next   = (px_next == '0) && (py_next == '0);
                        mb_last_next    = (px_next == s_last_reg) && (py_next == s_last_reg);
                        frame_last_next = mb_last_next && (mbx_next == cols_last_reg)
                                       && (mby_next == rows_last_reg);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            w_reg          <= '0;
            sw_reg         <= '0;
            s_last_reg     <= '0;
            cols_last_reg  <= '0;
            rows_last_reg  <= '0;
            px_reg         <= '0;
            py_reg         <= '0;
            mbx_reg        <= '0;
            mby_reg        <= '0;
            col_off_reg    <= '0;
            row_base_reg   <= '0;
            line_base_reg  <= '0;
            valid_reg      <= 1'b0;
            addr_reg       <= '0;
            mb_first_reg   <= 1'b0;
            mb_last_reg    <= 1'b0;
            frame_last_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            w_reg          <= w_next;
            sw_reg         <= sw_next;
            s_last_reg     <= s_last_next;
            cols_last_reg  <= cols_last_next;
            rows_last_reg  <= rows_last_next;
            px_reg         <= px_next;
            py_reg         <= py_next;
            mbx_reg        <= mbx_next;
            mby_reg        <= mby_next;
            col_off_reg    <= col_off_next;
            row_base_reg   <= row_base_next;
            line_base_reg  <= line_base_next;
            valid_reg      <= valid_next;
            addr_reg       <= addr_next;
            mb_first_reg   <= mb_first_next;
            mb_last_reg    <= mb_last_next;
            frame_last_reg <= frame_last_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        oBusy      = (state_reg == RUN);
        oErr       = err_reg;
        oDone      = done_reg;
        oValid     = valid_reg;
        oAddr      = addr_reg;
        oMbFirst   = mb_first_reg;
        oMbLast    = mb_last_reg;
        oFrameLast = frame_last_reg;
    end

endmodule

// File: tb/tb_mblk_scan_addr_gen.sv
// Directed bench for mblk_scan_addr_gen: full-frame scans, rejected starts,
// backpressure, mid-frame reset, ignored mid-frame inputs and back-to-back frames.
module tb_mblk_scan_addr_gen;

    localparam int DIM_W  = 12;
    localparam int ADDR_W = 22;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iStart;
    logic [1:0]        iMbType;
    logic [DIM_W-1:0]  iFrameW;
    logic [DIM_W-1:0]  iFrameH;
    logic              oBusy;
    logic              oErr;
    logic              oDone;
    logic              oValid;
    logic              iReady;
    logic [ADDR_W-1:0] oAddr;
    logic              oMbFirst;
    logic              oMbLast;
    logic              oFrameLast;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] cap_addr  [0:4095];
    logic [2:0]        cap_flags [0:4095];

    mblk_scan_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iMbType(iMbType),
        .iFrameW(iFrameW), .iFrameH(iFrameH), .oBusy(oBusy), .oErr(oErr),
        .oDone(oDone), .oValid(oValid), .iReady(iReady), .oAddr(oAddr),
        .oMbFirst(oMbFirst), .oMbLast(oMbLast), .oFrameLast(oFrameLast)
    );

    always #5 iClk = ~iClk;

    task automatic step;
        @(posedge iClk);
        #1;
    endtask

    // Reference beat: {addr, first, last, frame_last} straight from the scan-order formula
    function automatic logic [ADDR_W+2:0] exp_beat(int n, int s, int w, int h);
        int px, py, blk, cols, mbx, mby, a;
        logic f, l, fl;
        px   = n % s;
        py   = (n / s) % s;
        blk  = n / (s * s);
        cols = w / s;
        mbx  = blk % cols;
        mby  = blk / cols;
        a    = (mby * s + py) * w + mbx * s + px;
        f    = (px == 0) && (py == 0);
        l    = (px == s - 1) && (py == s - 1);
        fl   = (n == w * h - 1);
        return {ADDR_W'(a), f, l, fl};
    endfunction

    task automatic start_frame(input logic [1:0] t, input int w, input int h);
        iMbType = t;
        iFrameW = DIM_W'(w);
        iFrameH = DIM_W'(h);
        iStart  = 1'b1;
        step;
        iStart  = 1'b0;
    endtask

    // Consumes one frame's beats; abort_at >= 0 stops with beat abort_at still presented
    task automatic run_frame(input string tag, input int s, input int w, input int h,
                             input bit stall, input bit disturb, input int abort_at);
        int n, cyc, held, total, budget, exp_cyc;
        bit rdy;
        logic [ADDR_W+2:0] got, expv;
        total  = w * h;
        budget = 2 * total + 64;
        n = 0; cyc = 0; held = 0;
        while (n < total && cyc < budget) begin
            if (n == abort_at) break;
            rdy = 1'b1;
            if (stall && n >= 15 && n <= 17 && held < 3) begin
                rdy = 1'b0;
                held++;
            end
            iReady = rdy;
            if (disturb) begin
                iStart = (n == 100);
                if (n == 100) begin
                    iMbType = 2'b01;
                    iFrameW = DIM_W'(64);
                    iFrameH = DIM_W'(128);
                end
            end
            got  = {oAddr, oMbFirst, oMbLast, oFrameLast};
            expv = exp_beat(n, s, w, h);
            checks++;
            if (oValid !== 1'b1 || oBusy !== 1'b1 || oErr !== 1'b0 || oDone !== 1'b0 || got !== expv) begin
                errors++;
                $display("FAIL %s beat %0d: valid=%b busy=%b err=%b done=%b addr=%0d flags=%b, required valid=1 busy=1 err=0 done=0 addr=%0d flags=%b",
                         tag, n, oValid, oBusy, oErr, oDone, got[ADDR_W+2:3], got[2:0],
                         expv[ADDR_W+2:3], expv[2:0]);
            end
            if (rdy && oValid) begin
                cap_addr[n]  = oAddr;
                cap_flags[n] = {oMbFirst, oMbLast, oFrameLast};
                n++;
                held = 0;
            end
            step;
            cyc++;
        end
        iStart = 1'b0;
        iReady = 1'b1;
        if (abort_at < 0) begin
            exp_cyc = total + (stall ? 9 : 0);
            checks++;
            if (n != total) begin
                errors++;
                $display("FAIL %s beat_count: got %0d beats in %0d cycles, required %0d", tag, n, cyc, total);
            end
            checks++;
            if (cyc != exp_cyc) begin
                errors++;
                $display("FAIL %s cycle_count: got %0d cycles, required %0d", tag, cyc, exp_cyc);
            end
            checks++;
            if (oValid !== 1'b0 || oDone !== 1'b1 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL %s done_cycle: valid=%b done=%b busy=%b, required valid=0 done=1 busy=0",
                         tag, oValid, oDone, oBusy);
            end
            $display("frame %s: %0d beats, %0d cycles", tag, n, cyc);
        end
    endtask

    task automatic check_idle_after_done(input string tag);
        step;
        checks++;
        if (oDone !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b valid=%b busy=%b, required all 0", tag, oDone, oValid, oBusy);
        end
    endtask

    task automatic test_reset;
        iRst = 1'b1; iStart = 1'b0; iMbType = 2'b00; iFrameW = '0; iFrameH = '0; iReady = 1'b1;
        step;
        step;
        checks++;
        if ({oBusy, oErr, oDone, oValid, oAddr, oMbFirst, oMbLast, oFrameLast} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b err=%b done=%b valid=%b addr=%0d flags=%b%b%b, required all 0",
                     oBusy, oErr, oDone, oValid, oAddr, oMbFirst, oMbLast, oFrameLast);
        end
        iRst = 1'b0;
        step;
        $display("reset applied");
    endtask

    task automatic test_s16_frame;
        int hb [7] = '{0, 15, 16, 255, 256, 512, 1023};
        int ha [7] = '{0, 15, 32, 495, 16, 512, 1023};
        logic [2:0] hf [7] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b100, 3'b100, 3'b011};
        start_frame(2'b11, 32, 32);
        run_frame("s16", 16, 32, 32, 1'b0, 1'b0, -1);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap_addr[hb[i]] !== ADDR_W'(ha[i]) || cap_flags[hb[i]] !== hf[i]) begin
                errors++;
                $display("FAIL s16_point beat %0d: addr=%0d flags=%b, required addr=%0d flags=%b",
                         hb[i], cap_addr[hb[i]], cap_flags[hb[i]], ha[i], hf[i]);
            end
        end
        check_idle_after_done("s16");
    endtask

    task automatic test_s64_frame;
        int firsts;
        start_frame(2'b01, 64, 64);
        run_frame("s64", 64, 64, 64, 1'b0, 1'b0, -1);
        firsts = 0;
        for (int i = 0; i < 4096; i++) begin
            if (cap_flags[i][2]) firsts++;
        end
        checks++;
        if (firsts != 1) begin
            errors++;
            $display("FAIL s64_first_count: got %0d first flags, required 1", firsts);
        end
        checks++;
        if (cap_addr[4095] !== ADDR_W'(4095) || cap_flags[4095] !== 3'b011
            || cap_addr[64] !== ADDR_W'(64)) begin
            errors++;
            $display("FAIL s64_points: addr4095=%0d flags4095=%b addr64=%0d, required 4095 011 64",
                     cap_addr[4095], cap_flags[4095], cap_addr[64]);
        end
        check_idle_after_done("s64");
    endtask

    task automatic test_invalid_start;
        logic [1:0] t [4] = '{2'b00, 2'b11, 2'b10, 2'b01};
        int w [4] = '{32, 40, 0, 4032};
        int h [4] = '{32, 32, 32, 4032};
        for (int i = 0; i < 4; i++) begin
            start_frame(t[i], w[i], h[i]);
            checks++;
            if (oErr !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_%0d_pulse: err=%b valid=%b busy=%b, required err=1 valid=0 busy=0",
                         i, oErr, oValid, oBusy);
            end
            step;
            checks++;
            if (oErr !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_%0d_after: err=%b valid=%b busy=%b, required all 0",
                         i, oErr, oValid, oBusy);
            end
            $display("start rejected: type=%b w=%0d h=%0d", t[i], w[i], h[i]);
        end
    endtask

    task automatic test_backpressure;
        start_frame(2'b11, 32, 32);
        run_frame("stall", 16, 32, 32, 1'b1, 1'b0, -1);
        check_idle_after_done("stall");
    endtask

    task automatic test_reset_mid_frame;
        start_frame(2'b11, 32, 32);
        run_frame("abort", 16, 32, 32, 1'b0, 1'b0, 300);
        iRst = 1'b1;
        step;
        iRst = 1'b0;
        checks++;
        if ({oBusy, oErr, oDone, oValid, oAddr, oMbFirst, oMbLast, oFrameLast} !== '0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b err=%b done=%b valid=%b addr=%0d, required all 0",
                     oBusy, oErr, oDone, oValid, oAddr);
        end
        for (int i = 0; i < 5; i++) begin
            step;
            checks++;
            if (oDone !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet cycle %0d: done=%b valid=%b busy=%b, required all 0",
                         i, oDone, oValid, oBusy);
            end
        end
        $display("reset mid-frame at beat 300");
        start_frame(2'b11, 32, 32);
        run_frame("restart", 16, 32, 32, 1'b0, 1'b0, -1);
        check_idle_after_done("restart");
    endtask

    task automatic test_disturb;
        start_frame(2'b11, 32, 32);
        run_frame("disturb", 16, 32, 32, 1'b0, 1'b1, -1);
        check_idle_after_done("disturb");
    endtask

    task automatic test_back_to_back;
        start_frame(2'b11, 32, 32);
        run_frame("b2b_a", 16, 32, 32, 1'b0, 1'b0, -1);
        start_frame(2'b11, 32, 32);
        run_frame("b2b_b", 16, 32, 32, 1'b0, 1'b0, -1);
        check_idle_after_done("b2b_b");
    endtask

    initial begin
        test_reset();
        test_s16_frame();
        test_s64_frame();
        test_invalid_start();
        test_backpressure();
        test_reset_mid_frame();
        test_disturb();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
